xa_bf_rd_sched: RTL and testbench
=================================

# xa_bf_rd_sched

Round-robin scheduler that shares the single DDR3→input-RAM read engine between up to four beam-forming controllers (FA/TA channels). It accepts load requests (address, length) from each controller, issues one read at a time to the DDR3 read engine, and returns a per-requester completion pulse. That completion pulse drives the controller's RAM0/RAM1 load-complete input. A watchdog aborts reads that never complete.

## Interface
- P_REQ_NUM, 3'd4, number of requesters (2..4)
- P_TIMEOUT, 24'd1_000_000, WAIT-state cycle limit before abort (≥2)
- i_clk156m  in  1  clock, 156.25 MHz
- i_arst_n  in  1  asynchronous active-low reset (one clock; reset async, active-low)
- i_frame_time  in  4  frame counter; any change resets the round-robin pointer
- i_req  in  P_REQ_NUM  level request per requester, held until o_req_ack
- i_req_addr  in  32*P_REQ_NUM  DDR3 start address, requester k at [32k+31:32k], stable while i_req[k]=1
- i_req_len  in  16*P_REQ_NUM  burst count, requester k at [16k+15:16k]
- i_rd_endp  in  1  read-engine completion pulse
- o_req_ack  out  P_REQ_NUM  1-cycle grant pulse
- o_req_done  out  P_REQ_NUM  1-cycle completion pulse
- o_req_err  out  P_REQ_NUM  1-cycle timeout pulse
- o_rd_start  out  1  1-cycle read-engine start pulse
- o_rd_addr  out  32  granted address
- o_rd_len  out  16  granted length
- o_rd_sel  out  2  granted requester index (selects input-RAM write port)
- o_busy  out  1  high in every state except IDLE
- o_err_cnt  out  8  saturating timeout count

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ERR (one-hot).
- IDLE: if any i_req bit is set, choose the first set bit searching from ptr+1 (mod P_REQ_NUM). Latch index, address, and length, then go to ISSUE. ptr becomes the granted index.
- ISSUE (1 cycle): assert o_req_ack[sel]. If len≠0, assert o_rd_start and go to WAIT. If len=0, no start is issued and the next state is DONE.
- WAIT: i_rd_endp → DONE. The watchdog counts cycles in WAIT; reaching P_TIMEOUT-1 without endp → ERR.
- DONE (1 cycle): assert o_req_done[sel] → IDLE.
- ERR (1 cycle): assert o_req_err[sel], increment o_err_cnt (saturates at 255) → IDLE.
- i_rd_endp is accepted only in ISSUE (len≠0) and WAIT. Endp in ISSUE goes directly to DONE. Elsewhere, including a late endp after ERR, it is ignored.
- i_frame_time change sets ptr to P_REQ_NUM-1 so index 0 wins next. It does not abort an in-flight read.
- The requester must drop i_req[k] the cycle after its ack. If i_req[k] is still high in IDLE, that is a new request.
- Bits of i_req at or above P_REQ_NUM are ignored. o_rd_sel width is fixed at 2.
- o_rd_addr, o_rd_len, and o_rd_sel are held from ISSUE through the return to IDLE.

## Timing
- Reset values: all pulses 0, o_rd_addr/len/sel 0, o_busy 0, o_err_cnt 0, state IDLE, ptr P_REQ_NUM-1, watchdog 0.
- i_req seen in IDLE at cycle T → ack and o_rd_start at T+1, registered.
- i_rd_endp at cycle E → o_req_done at E+1, IDLE at E+2. The earliest next ack/start is E+3.
- Zero-length request: ack at T+1, done at T+2.
- Timeout: the first WAIT cycle is W. o_req_err is asserted at W+P_TIMEOUT.
- If i_rd_endp coincides with the final watchdog cycle, endp wins (DONE).
- Reset asserted mid-read: all outputs return to reset values immediately (async). Any later endp is ignored.

## Structure
- Shared package xa_bf_pkg: state one-hot constants, P_REQ_NUM max (4), address/length widths (32/16).
- Sub-module xa_bf_rr_arb: combinational round-robin priority pick (req vector, ptr → grant index, valid).
- The remainder (FSM, latch registers, watchdog, error counter) belongs in the top. Expected size is about 200 lines.

## Test plan
- Single request: req[1] with addr 0x0010_0000, len 0x0200 → ack[1] and start at T+1 with addr/len/sel=1 on the bus. Endp at E → done[1] at E+1.
- Fairness: all four requests held continuously, endp 5 cycles after each start → grants in order 0,1,2,3,0 with no repeat.
- Zero length: req[2], len 0 → ack[2] at T+1, done[2] at T+2, o_rd_start never asserted.
- Timeout: P_TIMEOUT=16, no endp → err[sel] 16 cycles after the first WAIT cycle, o_err_cnt=1. A later endp produces no done.
- Frame change: grant req[2]; change i_frame_time during WAIT; requests pending on 1 and 3 → the read in flight completes, and the next grant goes to 1.
- Reset mid-WAIT: assert i_arst_n low → o_busy=0 and all pulses 0. Endp after release → no done. A fresh req[3] is serviced normally.

Source files
------------

// File: rtl/xa_bf_pkg.sv
// Shared types and constants for the beam-forming DDR3 read scheduler.
// No logic; latency n/a.
// Backpressure n/a.
package xa_bf_pkg;

    localparam int REQ_MAX = 4;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 16;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_ISSUE = 5'b00010,
        ST_WAIT  = 5'b00100,
        ST_DONE  = 5'b01000,
        ST_ERR   = 5'b10000
    } state_t;

    function automatic logic [REQ_MAX-1:0] idx2oh(input logic [1:0] idx);
        return {{(REQ_MAX-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/xa_bf_rr_arb.sv
// Round-robin pick: first set request searching upward from ptr+1, wrapping at N.
// Latency: combinational.
// Backpressure: none; caller decides when to consume the grant.
module xa_bf_rr_arb
    import xa_bf_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [1:0]   gnt,
    output logic         vld
);

    logic [REQ_MAX-1:0] req_pad;
    logic [2:0]         idx;

    always_comb begin
        req_pad        = '0;
        req_pad[N-1:0] = req;
        gnt            = '0;
        vld            = 1'b0;
        idx            = '0;
        // ptr < N and i <= N, so a single wrap subtraction is enough
        for (int i = 1; i <= N; i++) begin
            idx = {1'b0, ptr} + 3'(i);
            if (idx >= 3'(N))
                idx = idx - 3'(N);
            if (!vld && req_pad[idx[1:0]]) begin
                vld = 1'b1;
                gnt = idx[1:0];
            end
        end
    end

endmodule

// File: rtl/xa_bf_rd_sched.sv
// Shares one DDR3 read engine between up to four controllers, round-robin, with watchdog abort.
// Latency: req seen in IDLE -> ack/start next cycle; endp -> done next cycle.
// Backpressure: requests held as levels until ack; one read outstanding at a time.
module xa_bf_rd_sched
    import xa_bf_pkg::*;
#(
    parameter int          P_REQ_NUM = 4,
    parameter logic [23:0] P_TIMEOUT = 24'd1_000_000
) (
    input  logic                        i_clk156m,
    input  logic                        i_arst_n,
    input  logic [3:0]                  i_frame_time,
    input  logic [P_REQ_NUM-1:0]        i_req,
    input  logic [ADDR_W*P_REQ_NUM-1:0] i_req_addr,
    input  logic [LEN_W*P_REQ_NUM-1:0]  i_req_len,
    input  logic                        i_rd_endp,
    output logic [P_REQ_NUM-1:0]        o_req_ack,
    output logic [P_REQ_NUM-1:0]        o_req_done,
    output logic [P_REQ_NUM-1:0]        o_req_err,
    output logic                        o_rd_start,
    output logic [ADDR_W-1:0]           o_rd_addr,
    output logic [LEN_W-1:0]            o_rd_len,
    output logic [1:0]                  o_rd_sel,
    output logic                        o_busy,
    output logic [7:0]                  o_err_cnt
);

    localparam logic [1:0] PTR_RST = 2'(P_REQ_NUM - 1);

    state_t               state;
    logic [1:0]           ptr;
    logic [1:0]           sel;
    logic [ADDR_W-1:0]    addr;
    logic [LEN_W-1:0]     len;
    logic [P_REQ_NUM-1:0] ack;
    logic [P_REQ_NUM-1:0] done;
    logic [P_REQ_NUM-1:0] err;
    logic                 start;
    logic [23:0]          wd;
    logic [7:0]           err_cnt;
    logic [3:0]           frame_q;

    logic                 frame_chg;
    logic [1:0]           gnt;
    logic                 gnt_vld;
    logic [REQ_MAX-1:0]   gnt_oh_full;
    logic [REQ_MAX-1:0]   sel_oh_full;
    logic [P_REQ_NUM-1:0] gnt_oh;
    logic [P_REQ_NUM-1:0] sel_oh;

    logic [ADDR_W-1:0]    addr_arr [REQ_MAX];
    logic [LEN_W-1:0]     len_arr  [REQ_MAX];

    for (genvar k = 0; k < REQ_MAX; k++) begin : g_slice
        if (k < P_REQ_NUM) begin : g_on
            assign addr_arr[k] = i_req_addr[ADDR_W*k +: ADDR_W];
            assign len_arr[k]  = i_req_len[LEN_W*k +: LEN_W];
        end else begin : g_off
            assign addr_arr[k] = '0;
            assign len_arr[k]  = '0;
        end
    end

    xa_bf_rr_arb #(
        .N (P_REQ_NUM)
    ) u_arb (
        .req (i_req),
        .ptr (ptr),
        .gnt (gnt),
        .vld (gnt_vld)
    );

    assign frame_chg   = (i_frame_time != frame_q);
    assign gnt_oh_full = idx2oh(gnt);
    assign sel_oh_full = idx2oh(sel);
    assign gnt_oh      = gnt_oh_full[P_REQ_NUM-1:0];
    assign sel_oh      = sel_oh_full[P_REQ_NUM-1:0];

    always_ff @(posedge i_clk156m or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state   <= ST_IDLE;
            ptr     <= PTR_RST;
            sel     <= '0;
            addr    <= '0;
            len     <= '0;
            ack     <= '0;
            done    <= '0;
            err     <= '0;
            start   <= 1'b0;
            wd      <= '0;
            err_cnt <= '0;
            frame_q <= '0;
        end else begin
            ack     <= '0;
            done    <= '0;
            err     <= '0;
            start   <= 1'b0;
            wd      <= '0;
            frame_q <= i_frame_time;
            // a new frame restarts fairness at index 0 without touching the read in flight
            if (frame_chg)
                ptr <= PTR_RST;
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        sel   <= gnt;
                        addr  <= addr_arr[gnt];
                        len   <= len_arr[gnt];
                        ack   <= gnt_oh;
                        start <= (len_arr[gnt] != '0);
                        if (!frame_chg)
                            ptr <= gnt;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (len == '0 || i_rd_endp) begin
                        done  <= sel_oh;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // endp on the last watchdog cycle still completes normally
                    if (i_rd_endp) begin
                        done  <= sel_oh;
                        state <= ST_DONE;
                    end else if (wd == P_TIMEOUT - 24'd1) begin
                        err   <= sel_oh;
                        if (err_cnt != 8'hFF)
                            err_cnt <= err_cnt + 8'd1;
                        state <= ST_ERR;
                    end else begin
                        wd <= wd + 24'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ack  = ack;
    assign o_req_done = done;
    assign o_req_err  = err;
    assign o_rd_start = start;
    assign o_rd_addr  = addr;
    assign o_rd_len   = len;
    assign o_rd_sel   = sel;
    assign o_busy     = (state != ST_IDLE);
    assign o_err_cnt  = err_cnt;

endmodule

// File: tb/tb_xa_bf_rd_sched.sv
// Scoreboard bench for xa_bf_rd_sched: stimulus pushes expected pulse events, a negedge monitor pops and compares.
module tb_xa_bf_rd_sched;

    logic         clk = 1'b0;
    logic         arst_n;
    logic [3:0]   frame_time;
    logic [3:0]   req;
    logic [127:0] req_addr;
    logic [63:0]  req_len;
    logic         rd_endp;
    logic [3:0]   req_ack, req_done, req_err;
    logic         rd_start;
    logic [31:0]  rd_addr;
    logic [15:0]  rd_len;
    logic [1:0]   rd_sel;
    logic         busy;
    logic [7:0]   err_cnt;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          c;
        logic [3:0]  ack;
        logic [3:0]  done;
        logic [3:0]  err;
        logic        start;
        logic [31:0] addr;
        logic [15:0] len;
        logic [1:0]  sel;
    } ev_t;

    ev_t sb[$];
    ev_t e;

    logic [31:0] addr_tab [4];
    logic [15:0] len_tab  [4];

    xa_bf_rd_sched #(
        .P_REQ_NUM (4),
        .P_TIMEOUT (24'd16)
    ) dut (
        .i_clk156m    (clk),
        .i_arst_n     (arst_n),
        .i_frame_time (frame_time),
        .i_req        (req),
        .i_req_addr   (req_addr),
        .i_req_len    (req_len),
        .i_rd_endp    (rd_endp),
        .o_req_ack    (req_ack),
        .o_req_done   (req_done),
        .o_req_err    (req_err),
        .o_rd_start   (rd_start),
        .o_rd_addr    (rd_addr),
        .o_rd_len     (rd_len),
        .o_rd_sel     (rd_sel),
        .o_busy       (busy),
        .o_err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].c < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event want_cyc=%0d ack=%b done=%b err=%b start=%b now=%0d",
                     e.c, e.ack, e.done, e.err, e.start, cyc);
        end
        if (req_ack != 4'b0 || req_done != 4'b0 || req_err != 4'b0 || rd_start) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d ack=%b done=%b err=%b start=%b sel=%0d",
                         cyc, req_ack, req_done, req_err, rd_start, rd_sel);
            end else begin
                e = sb.pop_front();
                if (e.c != cyc || req_ack !== e.ack || req_done !== e.done || req_err !== e.err ||
                    rd_start !== e.start || rd_addr !== e.addr || rd_len !== e.len || rd_sel !== e.sel) begin
                    errors++;
                    $display("FAIL event got cyc=%0d ack=%b done=%b err=%b st=%b a=%h l=%h s=%0d want cyc=%0d ack=%b done=%b err=%b st=%b a=%h l=%h s=%0d",
                             cyc, req_ack, req_done, req_err, rd_start, rd_addr, rd_len, rd_sel,
                             e.c, e.ack, e.done, e.err, e.start, e.addr, e.len, e.sel);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // kind: 0 = ack (+start if len!=0), 1 = done, 2 = err
    task automatic push(input int c, input int kind, input int k, input logic [15:0] ln);
        ev_t x;
        logic [3:0] oh;
        oh      = 4'b0001 << k;
        x.c     = c;
        x.ack   = (kind == 0) ? oh : 4'b0;
        x.done  = (kind == 1) ? oh : 4'b0;
        x.err   = (kind == 2) ? oh : 4'b0;
        x.start = (kind == 0) && (ln != 16'h0);
        x.addr  = addr_tab[k];
        x.len   = ln;
        x.sel   = 2'(k);
        sb.push_back(x);
    endtask

    task automatic set_len(input int k, input logic [15:0] ln);
        len_tab[k] = ln;
        req_len[16*k +: 16] = ln;
    endtask

    task automatic pulse_endp();
        rd_endp = 1'b1;
        tick(1);
        rd_endp = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        int s;
        addr_tab[0] = 32'h0000_1000;
        addr_tab[1] = 32'h0010_0000;
        addr_tab[2] = 32'h0020_0000;
        addr_tab[3] = 32'h0030_0000;
        arst_n     = 1'b0;
        frame_time = 4'd0;
        req        = 4'b0;
        rd_endp    = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        for (int k = 0; k < 4; k++) req_addr[32*k +: 32] = addr_tab[k];
        set_len(0, 16'h0040);
        set_len(1, 16'h0200);
        set_len(2, 16'h0100);
        set_len(3, 16'h0080);
        tick(3);
        arst_n = 1'b1;
        tick(1);

        // reset state
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_err_cnt", {24'b0, err_cnt}, 32'h0);
        check("rst_addr", rd_addr, 32'h0);
        check("rst_len_sel", {14'b0, rd_len, rd_sel}, 32'h0);

        // single request on 1
        t = cyc;
        req = 4'b0010;
        push(t + 1, 0, 1, 16'h0200);
        push(t + 5, 1, 1, 16'h0200);
        tick(1);
        req = 4'b0000;
        wait_cyc(t + 2);
        check("single_busy_wait", {31'b0, busy}, 32'h1);
        wait_cyc(t + 4);
        pulse_endp();
        wait_cyc(t + 6);
        check("single_busy_idle", {31'b0, busy}, 32'h0);

        // fairness: reset ptr via frame change, then hold all four
        frame_time = 4'd1;
        tick(2);
        t = cyc;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            push(t + 1 + 8*g, 0, g % 4, len_tab[g % 4]);
            push(t + 7 + 8*g, 1, g % 4, len_tab[g % 4]);
        end
        for (int g = 0; g < 5; g++) begin
            s = t + 1 + 8*g;
            wait_cyc(s);
            if (g == 4) req = 4'b0000;
            wait_cyc(s + 5);
            pulse_endp();
        end
        wait_cyc(t + 1 + 32 + 8);

        // zero length on 2
        set_len(2, 16'h0000);
        t = cyc;
        req = 4'b0100;
        push(t + 1, 0, 2, 16'h0000);
        push(t + 2, 1, 2, 16'h0000);
        tick(1);
        req = 4'b0000;
        wait_cyc(t + 4);
        check("zero_busy_idle", {31'b0, busy}, 32'h0);
        set_len(2, 16'h0100);

        // timeout on 3
        t = cyc;
        req = 4'b1000;
        push(t + 1, 0, 3, 16'h0080);
        push(t + 18, 2, 3, 16'h0080);
        tick(1);
        req = 4'b0000;
        wait_cyc(t + 17);
        check("tmo_busy_last_wait", {31'b0, busy}, 32'h1);
        wait_cyc(t + 18);
        check("tmo_err_cnt", {24'b0, err_cnt}, 32'h1);
        wait_cyc(t + 20);
        pulse_endp();
        tick(3);
        check("tmo_busy_after_late_endp", {31'b0, busy}, 32'h0);
        check("tmo_err_cnt_hold", {24'b0, err_cnt}, 32'h1);

        // frame change during read of 2, pending 1 and 3
        t = cyc;
        req = 4'b0100;
        push(t + 1, 0, 2, 16'h0100);
        tick(1);
        req = 4'b0000;
        wait_cyc(t + 3);
        frame_time = 4'd2;
        req = 4'b1010;
        push(t + 7, 1, 2, 16'h0100);
        push(t + 9, 0, 1, 16'h0200);
        wait_cyc(t + 6);
        pulse_endp();
        wait_cyc(t + 9);
        req = 4'b0000;
        push(t + 12, 1, 1, 16'h0200);
        wait_cyc(t + 11);
        pulse_endp();
        wait_cyc(t + 13);
        check("frame_busy_idle", {31'b0, busy}, 32'h0);

        // reset during WAIT of 3
        t = cyc;
        req = 4'b1000;
        push(t + 1, 0, 3, 16'h0080);
        tick(1);
        req = 4'b0000;
        wait_cyc(t + 4);
        check("mid_busy_before_rst", {31'b0, busy}, 32'h1);
        arst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_pulses", {19'b0, req_ack, req_done, req_err, rd_start}, 32'h0);
        check("mid_rst_addr", rd_addr, 32'h0);
        check("mid_rst_len_sel", {14'b0, rd_len, rd_sel}, 32'h0);
        check("mid_rst_err_cnt", {24'b0, err_cnt}, 32'h0);
        tick(2);
        arst_n = 1'b1;
        tick(1);
        pulse_endp();
        tick(2);
        check("post_rst_busy", {31'b0, busy}, 32'h0);
        t = cyc;
        req = 4'b1000;
        push(t + 1, 0, 3, 16'h0080);
        push(t + 5, 1, 3, 16'h0080);
        tick(1);
        req = 4'b0000;
        wait_cyc(t + 4);
        pulse_endp();
        wait_cyc(t + 6);
        check("fresh_busy_idle", {31'b0, busy}, 32'h0);

        tick(3);
        check("scoreboard_empty", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
